// File: rtl/pointer_unit.sv
// rtl/pointer_unit.sv - IP/DP pointer pair with selector-based role swap and address/ALU-B muxing.
// Optional POINTER_UNIT_WRAP_FLAG_EN adds a sticky ip_wrap output.
module pointer_unit #(
    parameter logic [15:0] RESET_P0 = 16'h0000,
    parameter logic [15:0] RESET_P1 = 16'h0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        p_selector,
    input  logic        inc_ip,
    input  logic        addr_dp,
    input  logic        n_we_pl,
    input  logic        n_we_ph,
    input  logic [7:0]  di,
    input  logic        n_oe_pl_alu,
    input  logic        n_oe_ph_alu,
    output logic [15:0] addr,
    output logic [7:0]  alu_b,
    output logic        n_alu_b_en
`ifdef POINTER_UNIT_WRAP_FLAG_EN
    ,
    output logic        ip_wrap
`endif
);

    logic [15:0] p0;
    logic [15:0] p1;
    logic [15:0] ip;
    logic [15:0] dp;
    logic [15:0] ip_next;
    logic [15:0] dp_next;

    // Roles are a pure view over the physical pair; a jump never moves data.
    assign ip = p_selector ? p1 : p0;
    assign dp = p_selector ? p0 : p1;

    always_comb begin
        ip_next = inc_ip ? ip + 16'd1 : ip;
        dp_next = dp;
        if (!n_we_pl) dp_next[7:0]  = di;
        if (!n_we_ph) dp_next[15:8] = di;
    end

    // Falling-edge update: the control unit settles its outputs on the rising edge.
    always_ff @(negedge clk or negedge n_rst) begin
        if (!n_rst) begin
            p0 <= RESET_P0;
            p1 <= RESET_P1;
        end else if (p_selector) begin
            p1 <= ip_next;
            p0 <= dp_next;
        end else begin
            p0 <= ip_next;
            p1 <= dp_next;
        end
    end

    assign addr = addr_dp ? dp : ip;

    always_comb begin
        alu_b      = 8'h00;
        n_alu_b_en = 1'b1;
        case ({n_oe_ph_alu, n_oe_pl_alu})
            2'b10: begin
                alu_b      = dp[7:0];
                n_alu_b_en = 1'b0;
            end
            2'b01: begin
                alu_b      = dp[15:8];
                n_alu_b_en = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef POINTER_UNIT_WRAP_FLAG_EN
    always_ff @(negedge clk or negedge n_rst) begin
        if (!n_rst)
            ip_wrap <= 1'b0;
        else if (inc_ip && ip == 16'hFFFF)
            ip_wrap <= 1'b1;
    end
`endif

    // Both byte enables low means the control unit is driving a contradictory request.
    oe_exclusive: assert property (@(negedge clk) disable iff (!n_rst)
        !(!n_oe_pl_alu && !n_oe_ph_alu))
        else $error("pointer_unit: n_oe_pl_alu and n_oe_ph_alu both asserted");

endmodule

// File: tb/tb_pointer_unit.sv
// tb/tb_pointer_unit.sv - scoreboard bench for pointer_unit.
module tb_pointer_unit;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        p_selector;
    logic        inc_ip;
    logic        addr_dp;
    logic        n_we_pl;
    logic        n_we_ph;
    logic [7:0]  di;
    logic        n_oe_pl_alu;
    logic        n_oe_ph_alu;
    logic [15:0] addr;
    logic [7:0]  alu_b;
    logic        n_alu_b_en;
`ifdef POINTER_UNIT_WRAP_FLAG_EN
    logic        ip_wrap;
`endif

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [7:0]  alu;
        logic        en;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pointer_unit dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .p_selector  (p_selector),
        .inc_ip      (inc_ip),
        .addr_dp     (addr_dp),
        .n_we_pl     (n_we_pl),
        .n_we_ph     (n_we_ph),
        .di          (di),
        .n_oe_pl_alu (n_oe_pl_alu),
        .n_oe_ph_alu (n_oe_ph_alu),
        .addr        (addr),
        .alu_b       (alu_b),
        .n_alu_b_en  (n_alu_b_en)
`ifdef POINTER_UNIT_WRAP_FLAG_EN
        ,
        .ip_wrap     (ip_wrap)
`endif
    );

    // Drive one control-unit cycle: change after the rising edge, sample after the falling edge.
    task automatic tick(input logic inc, input logic we_pl, input logic we_ph, input logic [7:0] d);
        @(posedge clk);
        #1;
        inc_ip  = inc;
        n_we_pl = we_pl;
        n_we_ph = we_ph;
        di      = d;
        @(negedge clk);
        #1;
        inc_ip  = 1'b0;
        n_we_pl = 1'b1;
        n_we_ph = 1'b1;
        di      = 8'h00;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; p_selector = 1'b0; inc_ip = 1'b0; addr_dp = 1'b0;
        n_we_pl = 1'b1; n_we_ph = 1'b1; di = 8'h00; n_oe_pl_alu = 1'b1; n_oe_ph_alu = 1'b1;
        #3;
        sb.push_back('{"reset_state", 16'h0000, 8'h00, 1'b1});
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        @(posedge clk); #1;
        inc_ip = 1'b1; n_we_pl = 1'b0; n_we_ph = 1'b0; di = 8'h55; addr_dp = 1'b1;
        sb.push_back('{"reset_ignores_writes_dp", 16'h0000, 8'h00, 1'b1});
        sb.push_back('{"reset_ignores_inc_ip", 16'h0000, 8'h00, 1'b1});
        @(negedge clk); #1;
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        addr_dp = 1'b0; #1;
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        inc_ip = 1'b0; n_we_pl = 1'b1; n_we_ph = 1'b1; di = 8'h00;
        @(posedge clk); #1;
        n_rst = 1'b1;
    endtask

    task automatic test_dp_load();
        addr_dp = 1'b1;
        sb.push_back('{"dp_low_byte", 16'h0034, 8'h00, 1'b1});
        tick(1'b0, 1'b0, 1'b1, 8'h34);
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        sb.push_back('{"dp_high_byte", 16'h1234, 8'h00, 1'b1});
        tick(1'b0, 1'b1, 1'b0, 8'h12);
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        n_oe_ph_alu = 1'b0; #1;
        sb.push_back('{"alu_b_high", 16'h1234, 8'h12, 1'b0});
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        n_oe_ph_alu = 1'b1; n_oe_pl_alu = 1'b0; #1;
        sb.push_back('{"alu_b_low", 16'h1234, 8'h34, 1'b0});
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        n_oe_pl_alu = 1'b1; addr_dp = 1'b0; #1;
        sb.push_back('{"ip_untouched_by_dp_load", 16'h0000, 8'h00, 1'b1});
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
    endtask

    task automatic test_increment();
        for (int i = 1; i <= 3; i++) begin
            sb.push_back('{$sformatf("inc_ip_%0d", i), 16'(i), 8'h00, 1'b1});
            tick(1'b1, 1'b1, 1'b1, 8'h00);
            e = sb.pop_front(); checks++;
            if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        end
        addr_dp = 1'b1; #1;
        sb.push_back('{"dp_held_during_inc", 16'h1234, 8'h00, 1'b1});
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        addr_dp = 1'b0;
    endtask

    task automatic test_jump();
        p_selector = 1'b1; #1;
        sb.push_back('{"jump_ip_view", 16'h1234, 8'h00, 1'b1});
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        addr_dp = 1'b1; #1;
        sb.push_back('{"jump_dp_view", 16'h0003, 8'h00, 1'b1});
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        addr_dp = 1'b0;
        sb.push_back('{"inc_after_jump", 16'h1235, 8'h00, 1'b1});
        tick(1'b1, 1'b1, 1'b1, 8'h00);
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        addr_dp = 1'b1; #1;
        sb.push_back('{"dp_held_after_jump_inc", 16'h0003, 8'h00, 1'b1});
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        addr_dp = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Build IP=00FF, DP=5500 purely through DP writes and a selector toggle.
        tick(1'b0, 1'b0, 1'b1, 8'hFF);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        p_selector = 1'b0;
        tick(1'b0, 1'b1, 1'b0, 8'h55);
        tick(1'b0, 1'b0, 1'b1, 8'h00);
        addr_dp = 1'b1;
        sb.push_back('{"same_edge_dp", 16'h55AA, 8'h00, 1'b1});
        sb.push_back('{"same_edge_ip", 16'h0100, 8'h00, 1'b1});
        tick(1'b1, 1'b0, 1'b1, 8'hAA);
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
        addr_dp = 1'b0; #1;
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b0, 1'b0, 8'hFF);
        p_selector = 1'b1; #1;
        sb.push_back('{"ip_at_ffff", 16'hFFFF, 8'h00, 1'b1});
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
`ifdef POINTER_UNIT_WRAP_FLAG_EN
        checks++;
        if (ip_wrap !== 1'b0) begin errors++; $display("FAIL ip_wrap_before: got %b want 0", ip_wrap); end
`endif
        sb.push_back('{"ip_wraps_to_zero", 16'h0000, 8'h00, 1'b1});
        tick(1'b1, 1'b1, 1'b1, 8'h00);
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
`ifdef POINTER_UNIT_WRAP_FLAG_EN
        checks++;
        if (ip_wrap !== 1'b1) begin errors++; $display("FAIL ip_wrap_set: got %b want 1", ip_wrap); end
`endif
        sb.push_back('{"inc_after_wrap", 16'h0001, 8'h00, 1'b1});
        tick(1'b1, 1'b1, 1'b1, 8'h00);
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
`ifdef POINTER_UNIT_WRAP_FLAG_EN
        checks++;
        if (ip_wrap !== 1'b1) begin errors++; $display("FAIL ip_wrap_sticky: got %b want 1", ip_wrap); end
`endif
    endtask

    task automatic test_async_reset();
        @(posedge clk); #2;
        n_rst = 1'b0; #1;
        sb.push_back('{"async_reset_mid_cycle", 16'h0000, 8'h00, 1'b1});
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
`ifdef POINTER_UNIT_WRAP_FLAG_EN
        checks++;
        if (ip_wrap !== 1'b0) begin errors++; $display("FAIL ip_wrap_cleared: got %b want 0", ip_wrap); end
`endif
        p_selector = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        sb.push_back('{"first_edge_after_release", 16'h0001, 8'h00, 1'b1});
        tick(1'b1, 1'b1, 1'b1, 8'h00);
        e = sb.pop_front(); checks++;
        if ({addr, alu_b, n_alu_b_en} !== {e.addr, e.alu, e.en}) begin errors++; $display("FAIL %s: got addr=%h alu_b=%h en=%b want addr=%h alu_b=%h en=%b", e.name, addr, alu_b, n_alu_b_en, e.addr, e.alu, e.en); end
    endtask

    initial begin
        test_reset();
        test_dp_load();
        test_increment();
        test_jump();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
